hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RV32I core. It replaces the single-cycle load-use and forwarding unit. It adds freeze support for a variable-latency data memory and a multi-cycle execute unit such as the divider, plus a timeout watchdog on that unit. It sits beside the pipeline registers and drives their stall and flush enables and the E-stage operand forwarding muxes.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select for the E stage; M results win over W results.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rd_addr_M,
  input  logic [REG_AW-1:0] rd_addr_W,
  input  logic              rd_wren_M,
  input  logic              rd_wren_W,
  output fwd_sel_e          fwd_sel
);

  always_comb begin
    fwd_sel = FWD_NONE;
    if (rd_wren_M && (rd_addr_M != REG_AW'(REG_X0)) && (rd_addr_M == rs_addr))
      fwd_sel = FWD_M;
    else if (rd_wren_W && (rd_addr_W != REG_AW'(REG_X0)) && (rd_addr_W == rs_addr))
      fwd_sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage core with multi-cycle unit watchdog.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] rs1_addr_D,
  input  logic [REG_AW-1:0] rs2_addr_D,
  input  logic [REG_AW-1:0] rs1_addr_E,
  input  logic [REG_AW-1:0] rs2_addr_E,
  input  logic [REG_AW-1:0] rd_addr_E,
  input  logic [REG_AW-1:0] rd_addr_M,
  input  logic [REG_AW-1:0] rd_addr_W,
  input  logic              rd_wren_E,
  input  logic              rd_wren_M,
  input  logic              rd_wren_W,
  input  logic [1:0]        wb_sel_E,
  input  logic              ld_M,
  input  logic              dmem_ready,
  input  logic              mc_start_E,
  input  logic              mc_done,
  input  logic              br_sel,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        forward_A_E,
  output logic [1:0]        forward_B_E,
  output logic              mc_busy,
  output logic              mc_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cyc_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int TW = $clog2(MC_TIMEOUT) + 1;

  mc_state_e   state;
  logic [TW-1:0] mc_cnt;
  logic        mc_suppress;
  fwd_sel_e    fwd_a, fwd_b;
  logic        mw, mcs, lus, lus_eff, mc_start_eff, stall_e_raw, br_eff;
  logic        unused_wb_sel;

  assign unused_wb_sel = wb_sel_E[1];

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_addr(rs1_addr_E), .rd_addr_M(rd_addr_M), .rd_addr_W(rd_addr_W),
    .rd_wren_M(rd_wren_M), .rd_wren_W(rd_wren_W), .fwd_sel(fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_addr(rs2_addr_E), .rd_addr_M(rd_addr_M), .rd_addr_W(rd_addr_W),
    .rd_wren_M(rd_wren_M), .rd_wren_W(rd_wren_W), .fwd_sel(fwd_b)
  );

  // After a watchdog abort the stuck instruction's start is masked until E advances.
  assign mc_start_eff = mc_start_E && !mc_suppress;
  assign mw           = ld_M && !dmem_ready;
  assign mcs          = mc_start_eff && !mc_done;
  assign lus          = wb_sel_E[0] && rd_wren_E && (rd_addr_E != REG_AW'(REG_X0)) &&
                        ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));
  assign lus_eff      = lus && !mw && !mcs;
  assign stall_e_raw  = mw || mcs;
  assign br_eff       = br_sel && !stall_e_raw;

  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    FlushW      = 1'b0;
    forward_A_E = FWD_NONE;
    forward_B_E = FWD_NONE;
    if (!i_rst) begin
      StallF      = mw || mcs || lus_eff;
      StallD      = mw || mcs || lus_eff;
      StallE      = stall_e_raw;
      StallM      = mw;
      FlushD      = br_eff;
      FlushE      = br_eff || lus_eff;
      FlushM      = mcs && !mw;
      FlushW      = mw;
      forward_A_E = fwd_a;
      forward_B_E = fwd_b;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      mc_cnt      <= '0;
      mc_timeout  <= 1'b0;
      mc_suppress <= 1'b0;
    end else begin
      if (mc_suppress && !stall_e_raw)
        mc_suppress <= 1'b0;
      if (state == IDLE) begin
        if (mc_start_eff && !mc_done && !mw) begin
          state  <= BUSY;
          mc_cnt <= TW'(1);
        end
      end else begin
        if (mc_done) begin
          state <= IDLE;
        end else if (mc_cnt == TW'(MC_TIMEOUT - 1)) begin
          state       <= IDLE;
          mc_timeout  <= 1'b1;
          mc_suppress <= 1'b1;
        end else begin
          mc_cnt <= mc_cnt + TW'(1);
        end
      end
    end
  end

  assign mc_busy = (state == BUSY);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cyc_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (StallF && (stall_cyc_cnt != '1))
        stall_cyc_cnt <= stall_cyc_cnt + CNT_W'(1);
      if (FlushD && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-vector queue and immediate assertions.
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [REG_AW-1:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
  logic [REG_AW-1:0] rd_addr_E, rd_addr_M, rd_addr_W;
  logic              rd_wren_E, rd_wren_M, rd_wren_W;
  logic [1:0]        wb_sel_E;
  logic              ld_M, dmem_ready, mc_start_E, mc_done, br_sel;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushM, FlushW;
  logic [1:0]        forward_A_E, forward_B_E;
  logic              mc_busy, mc_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cyc_cnt, flush_cnt;
`endif

  logic [13:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [13:0] obs;

  hazard_ctrl #(.REG_AW(REG_AW), .MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E), .rd_addr_E(rd_addr_E),
    .rd_addr_M(rd_addr_M), .rd_addr_W(rd_addr_W),
    .rd_wren_E(rd_wren_E), .rd_wren_M(rd_wren_M), .rd_wren_W(rd_wren_W),
    .wb_sel_E(wb_sel_E), .ld_M(ld_M), .dmem_ready(dmem_ready),
    .mc_start_E(mc_start_E), .mc_done(mc_done), .br_sel(br_sel),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
    .mc_busy(mc_busy), .mc_timeout(mc_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cyc_cnt(stall_cyc_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                forward_A_E, forward_B_E, mc_busy, mc_timeout};

  // {stall F,D,E,M} {flush D,E,M,W} fwdA fwdB busy timeout
  function automatic logic [13:0] ev(input logic [3:0] st, input logic [3:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic bz, input logic to);
    return {st, fl, fa, fb, bz, to};
  endfunction

  task automatic clr();
    rs1_addr_D = '0; rs2_addr_D = '0; rs1_addr_E = '0; rs2_addr_E = '0;
    rd_addr_E = '0; rd_addr_M = '0; rd_addr_W = '0;
    rd_wren_E = 1'b0; rd_wren_M = 1'b0; rd_wren_W = 1'b0;
    wb_sel_E = 2'b00; ld_M = 1'b0; dmem_ready = 1'b0;
    mc_start_E = 1'b0; mc_done = 1'b0; br_sel = 1'b0;
  endtask

  // push expectation, compare at the falling edge, then advance one cycle
  task automatic cyc(input string tag, input logic [13:0] e);
    logic [13:0] x;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge i_clk);
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", t, obs, x);
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    clr();
    i_rst = 1'b1;
    ld_M = 1'b1; rd_wren_M = 1'b1; rd_addr_M = 5'd5; rs1_addr_E = 5'd5;
    br_sel = 1'b1; mc_start_E = 1'b1;
    cyc("reset_zero", '0);
    i_rst = 1'b0;
    clr();

    rd_addr_M = 5'd5; rd_addr_W = 5'd5; rd_wren_M = 1'b1; rd_wren_W = 1'b1;
    rs1_addr_E = 5'd5; rs2_addr_E = 5'd6;
    cyc("fwd_m_prio", ev(4'b0000, 4'b0000, 2'b10, 2'b00, 1'b0, 1'b0));
    rd_addr_W = 5'd6;
    cyc("fwd_m_and_w", ev(4'b0000, 4'b0000, 2'b10, 2'b01, 1'b0, 1'b0));
    rd_addr_M = 5'd0; rd_addr_W = 5'd0; rs1_addr_E = 5'd0; rs2_addr_E = 5'd0;
    cyc("fwd_x0", ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
    rd_wren_M = 1'b0; rd_addr_M = 5'd5; rd_addr_W = 5'd5; rs1_addr_E = 5'd5;
    cyc("fwd_w_only", ev(4'b0000, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0));
    clr();

    wb_sel_E = 2'b01; rd_wren_E = 1'b1; rd_addr_E = 5'd7; rs2_addr_D = 5'd7;
    cyc("lus", ev(4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0));
    clr();
    cyc("lus_bubble", '0);
    wb_sel_E = 2'b01; rd_wren_E = 1'b1; rd_addr_E = 5'd0;
    cyc("lus_x0", '0);
    wb_sel_E = 2'b00; rd_addr_E = 5'd7; rs2_addr_D = 5'd7;
    cyc("lus_not_load", '0);
    clr();

    ld_M = 1'b1; br_sel = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mem_wait", ev(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 1'b0));
    dmem_ready = 1'b1;
    cyc("mem_release_br", ev(4'b0000, 4'b1100, 2'b00, 2'b00, 1'b0, 1'b0));
    clr();

    mc_start_E = 1'b1;
    cyc("mc_start", ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) cyc("mc_busy", ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b1, 1'b0));
    mc_done = 1'b1;
    cyc("mc_done", ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0));
    clr();
    cyc("mc_idle", '0);
    mc_start_E = 1'b1; mc_done = 1'b1;
    cyc("mc_zero_lat", '0);
    clr();
    cyc("mc_zero_idle", '0);

    mc_start_E = 1'b1; ld_M = 1'b1;
    cyc("mc_with_mw", ev(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 1'b0));
    dmem_ready = 1'b1;
    cyc("mc_mw_release", ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 1'b0));
    ld_M = 1'b0; mc_done = 1'b1;
    cyc("mc_mw_done", ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0));
    clr();
    cyc("mc_idle2", '0);

    mc_start_E = 1'b1;
    cyc("to_start", ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) cyc("to_busy", ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b1, 1'b0));
    cyc("to_suppress", ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1));
    mc_start_E = 1'b0;
    cyc("to_sticky", ev(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1));
    mc_start_E = 1'b1;
    cyc("to_restart", ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 1'b1));
    cyc("to_busy2", ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b1, 1'b1));
    i_rst = 1'b1;
    cyc("rst_mid_busy", '0);
    i_rst = 1'b0;
    clr();
    cyc("rst_idle", '0);

    ld_M = 1'b1;
    for (int i = 0; i < 10; i++) cyc("perf_stall", ev(4'b1111, 4'b0001, 2'b00, 2'b00, 1'b0, 1'b0));
    clr();
    br_sel = 1'b1;
    for (int i = 0; i < 2; i++) cyc("perf_br", ev(4'b0000, 4'b1100, 2'b00, 2'b00, 1'b0, 1'b0));
    clr();
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert (stall_cyc_cnt === CNT_W'(10)) else begin
      errors++;
      $error("FAIL stall_cyc_cnt observed %0d expected 10", stall_cyc_cnt);
    end
    checks++;
    assert (flush_cnt === CNT_W'(2)) else begin
      errors++;
      $error("FAIL flush_cnt observed %0d expected 2", flush_cnt);
    end
`endif
    mc_start_E = 1'b1;
    cyc("post_rst_mc", ev(4'b1110, 4'b0010, 2'b00, 2'b00, 1'b0, 1'b0));
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
